booth_scheduler: RTL

- Controller and two-port scheduler for the radix-2 Booth multiplier datapath.
- Accepts multiply requests from two requesters over valid/ready handshakes and arbitrates between them round-robin.
- Drives the datapath operands and the en_i/en_pp/en_fp/valid_in strobes through a fixed step sequence.
- Captures the product and returns it with the requester id over a valid/ready response channel.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/booth_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and default sizes for the Booth multiplier scheduler.
// The output struct groups the registered strobes so they move together.
package booth_pkg;

    localparam int DEFAULT_WIDTH_IN = 16;
    localparam int DEFAULT_WIDTH_FP = 32;
    localparam int DEFAULT_WIDTH_CO = 4;
    localparam int STEP_LAST        = DEFAULT_WIDTH_IN - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STEP    = 3'd2,
        S_FINAL   = 3'd3,
        S_CAPTURE = 3'd4,
        S_RESP    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic en_i;
        logic en_pp;
        logic en_fp;
        logic rsp_valid;
        logic busy;
    } sched_out_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The last-grant pointer moves only when the grant is actually taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_id,
    output logic       grant_valid
);

    logic last_r;

    // grant selection from current requests and last-grant pointer
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = ~last_r;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end else begin
            grant_id = 1'b0;
        end
    end

    // pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= 1'b1;
        end else if (advance) begin
            last_r <= grant_id;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/booth_scheduler.sv
// Two-port scheduler and sequencer for a radix-2 Booth multiplier datapath.
// Strobes, busy and rsp_valid are registered from the next-state decode.
module booth_scheduler
    import booth_pkg::*;
#(
    parameter int WIDTH_IN = DEFAULT_WIDTH_IN,
    parameter int WIDTH_FP = DEFAULT_WIDTH_FP,
    parameter int WIDTH_CO = DEFAULT_WIDTH_CO
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH_IN-1:0] req0_a,
    input  logic [WIDTH_IN-1:0] req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH_IN-1:0] req1_a,
    input  logic [WIDTH_IN-1:0] req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH_FP-1:0] rsp_product,
    output logic                busy,
    output logic [WIDTH_IN-1:0] dp_multiplicand,
    output logic [WIDTH_IN-1:0] dp_multiplier,
    output logic                dp_en_i,
    output logic                dp_en_pp,
    output logic                dp_en_fp,
    output logic                dp_valid_in,
    input  logic [WIDTH_FP-1:0] dp_product
);

    localparam logic [WIDTH_CO-1:0] STEP_END = WIDTH_CO'(WIDTH_IN - 1);

    sched_state_t        state_r, state_s;
    sched_out_t          out_r, out_s;
    logic [WIDTH_CO-1:0] cnt_r;
    logic [WIDTH_IN-1:0] a_r, b_r;
    logic                id_r, rsp_id_r;
    logic [WIDTH_FP-1:0] prod_r;
    logic                grant_id_s, grant_valid_s, accept_s;

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         ({req1_valid, req0_valid}),
        .advance     (accept_s),
        .grant_id    (grant_id_s),
        .grant_valid (grant_valid_s)
    );

    assign accept_s   = (state_r == S_IDLE) & grant_valid_s;
    assign req0_ready = accept_s & ~grant_id_s;
    assign req1_ready = accept_s & grant_id_s;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:    state_s = accept_s ? S_LOAD : S_IDLE;
            S_LOAD:    state_s = S_STEP;
            S_STEP:    state_s = (cnt_r == STEP_END) ? S_FINAL : S_STEP;
            S_FINAL:   state_s = S_CAPTURE;
            S_CAPTURE: state_s = S_RESP;
            S_RESP:    state_s = rsp_ready ? S_IDLE : S_RESP;
            default:   state_s = S_IDLE;
        endcase
    end

    // output decode of the upcoming state, registered below
    always_comb begin
        out_s = '0;
        case (state_s)
            S_IDLE:    out_s = '0;
            S_LOAD:    begin out_s.en_i  = 1'b1; out_s.busy = 1'b1; end
            S_STEP:    begin out_s.en_pp = 1'b1; out_s.busy = 1'b1; end
            S_FINAL:   begin out_s.en_fp = 1'b1; out_s.busy = 1'b1; end
            S_CAPTURE: out_s.busy = 1'b1;
            S_RESP:    begin out_s.rsp_valid = 1'b1; out_s.busy = 1'b1; end
            default:   out_s = '0;
        endcase
    end

    // registered strobes and status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r <= '0;
        end else begin
            out_r <= out_s;
        end
    end

    // step counter, operand latch and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            id_r     <= 1'b0;
            prod_r   <= '0;
            rsp_id_r <= 1'b0;
        end else begin
            if (state_r == S_LOAD) begin
                cnt_r <= '0;
            end else if (state_r == S_STEP) begin
                cnt_r <= cnt_r + WIDTH_CO'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                a_r  <= grant_id_s ? req1_a : req0_a;
                b_r  <= grant_id_s ? req1_b : req0_b;
                id_r <= grant_id_s;
            end
            if (state_r == S_CAPTURE) begin
                prod_r   <= dp_product;
                rsp_id_r <= id_r;
            end
        end
    end

    assign dp_en_i         = out_r.en_i;
    assign dp_valid_in     = out_r.en_i;
    assign dp_en_pp        = out_r.en_pp;
    assign dp_en_fp        = out_r.en_fp;
    assign rsp_valid       = out_r.rsp_valid;
    assign busy            = out_r.busy;
    assign dp_multiplicand = a_r;
    assign dp_multiplier   = b_r;
    assign rsp_product     = prod_r;
    assign rsp_id          = rsp_id_r;

endmodule
